// File: rtl/lfsr_rr_server_if.sv
// Requester-side bundle of lfsr_rr_server: request/grant handshake plus the
// random value that goes with each grant.
// Handshake: a requester raises req[i] and holds it until it sees gnt[i];
// gnt[i] and rnd_valid are high together for exactly one cycle, and
// rnd_data is meaningful in that cycle and holds until the next grant.
interface lfsr_rr_server_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rnd_valid;
  logic [12:0]     rnd_data;

  modport master (output req, input gnt, input rnd_valid, input rnd_data);
  modport slave  (input req, output gnt, output rnd_valid, output rnd_data);
endinterface

// File: rtl/lfsr_rr_server.sv
// 13-bit Fibonacci LFSR (x^13+x^4+x^3+x+1) shared by NREQ requesters.
// Each grant forces one fresh advance and delivers the new value; with no
// request pending the LFSR free-runs on step_tick.
// Optional macro LFSR_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of round-robin.
// fsm_state exposes the FSM state (IDLE=0, STEP=1, GRANT=2).
module lfsr_rr_server #(
  parameter int          NREQ = 4,
  parameter logic [12:0] SEED = 13'h0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_tick,
  input  logic              seed_load,
  input  logic [12:0]       seed_val,
  output logic [12:0]       lfsr_out,
  output logic              max_tick,
  output logic              busy,
  output logic [1:0]        fsm_state,
  lfsr_rr_server_if.slave   rr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, GRANT = 2'd2} state_t;

  state_t          state_q, state_n;
  logic [12:0]     lfsr_q, lfsr_n, lfsr_adv;
  logic [12:0]     cnt_q, cnt_n;
  logic [IW-1:0]   win_q, win_n, pick;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic            valid_q, valid_n;
  logic [12:0]     data_q, data_n;
  logic            tick_q, tick_n;
  logic            do_adv;
`ifndef LFSR_FIXED_PRIO_EN
  logic [IW-1:0]   last_q, last_n;
`endif

  assign lfsr_adv     = {lfsr_q[11:0], lfsr_q[12] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0]};
  assign lfsr_out     = lfsr_q;
  assign max_tick     = tick_q;
  assign busy         = (state_q != IDLE);
  assign fsm_state    = state_q;
  assign rr.gnt       = gnt_q;
  assign rr.rnd_valid = valid_q;
  assign rr.rnd_data  = data_q;

  // Arbitration: choose the winner among the currently requesting inputs.
  always_comb begin
    pick = '0;
`ifdef LFSR_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rr.req[i]) pick = IW'(i);
    end
`else
    // Scan downward so the smallest offset from last+1 is assigned last.
    for (int k = NREQ; k >= 1; k--) begin
      int t;
      t = int'(last_q) + k;
      if (t >= NREQ) t = t - NREQ;
      if (rr.req[t]) pick = IW'(t);
    end
`endif
  end

  // Next-state and registered-output logic; seed_load overrides everything.
  always_comb begin
    state_n = state_q;
    lfsr_n  = lfsr_q;
    cnt_n   = cnt_q;
    win_n   = win_q;
    gnt_n   = '0;
    valid_n = 1'b0;
    data_n  = data_q;
    tick_n  = 1'b0;
    do_adv  = 1'b0;
`ifndef LFSR_FIXED_PRIO_EN
    last_n  = last_q;
`endif
    case (state_q)
      IDLE: begin
        // A request wins over step_tick so a grant costs exactly one advance.
        if (|rr.req) begin
          win_n   = pick;
          state_n = STEP;
        end else if (step_tick) begin
          do_adv = 1'b1;
        end
      end
      STEP: begin
        do_adv       = 1'b1;
        gnt_n[win_q] = 1'b1;
        valid_n      = 1'b1;
        data_n       = lfsr_adv;
`ifndef LFSR_FIXED_PRIO_EN
        last_n       = win_q;
`endif
        state_n      = GRANT;
      end
      GRANT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (do_adv) begin
      lfsr_n = lfsr_adv;
      cnt_n  = (cnt_q == 13'd8190) ? 13'd0 : cnt_q + 13'd1;
      tick_n = (cnt_q == 13'd8190);
    end
    if (seed_load) begin
      lfsr_n  = (seed_val == 13'd0) ? SEED : seed_val;
      cnt_n   = 13'd0;
      state_n = IDLE;
      gnt_n   = '0;
      valid_n = 1'b0;
      tick_n  = 1'b0;
      data_n  = data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= 13'd0;
      win_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 13'd0;
      tick_q  <= 1'b0;
`ifndef LFSR_FIXED_PRIO_EN
      last_q  <= IW'(NREQ - 1);
`endif
    end else begin
      state_q <= state_n;
      lfsr_q  <= lfsr_n;
      cnt_q   <= cnt_n;
      win_q   <= win_n;
      gnt_q   <= gnt_n;
      valid_q <= valid_n;
      data_q  <= data_n;
      tick_q  <= tick_n;
`ifndef LFSR_FIXED_PRIO_EN
      last_q  <= last_n;
`endif
    end
  end

endmodule

// File: tb/tb_lfsr_rr_server.sv
// Bench for lfsr_rr_server: directed scenarios plus randomized rounds,
// grants checked by a scoreboard fed from a high-level model.
module tb_lfsr_rr_server;

  localparam int          NREQ = 4;
  localparam logic [12:0] SEED = 13'h0001;
  localparam int          EW   = NREQ + 13;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_tick = 1'b0;
  logic        seed_load = 1'b0;
  logic [12:0] seed_val = 13'd0;
  logic [12:0] lfsr_out;
  logic        max_tick;
  logic        busy;
  logic [1:0]  fsm_state;

  lfsr_rr_server_if #(.NREQ(NREQ)) rr ();

  lfsr_rr_server #(.NREQ(NREQ), .SEED(SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .step_tick (step_tick),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .lfsr_out  (lfsr_out),
    .max_tick  (max_tick),
    .busy      (busy),
    .fsm_state (fsm_state),
    .rr        (rr.slave)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Counters and scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  int tick_seen = 0;
  int exp_ticks = 0;

  // Reference model: LFSR value, step count within the period, RR pointer
  logic [12:0]     model_lfsr;
  int              model_steps;
  int              model_last;
  logic [12:0]     model_data;
  logic [NREQ-1:0] pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req_v, $time);
    end
  endtask

  function automatic logic [12:0] poly_step(input logic [12:0] v);
    // x^13 + x^4 + x^3 + x + 1, shifting toward the MSB
    return {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
  endfunction

  task automatic model_adv();
    model_lfsr = poly_step(model_lfsr);
    model_steps++;
    if (model_steps == 8191) begin
      model_steps = 0;
      exp_ticks++;
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] p);
`ifdef LFSR_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (p[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) begin
      if (p[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
    end
`endif
    return 0;
  endfunction

  // Monitor: pops an expected grant whenever the DUT presents one
  always @(negedge clk) begin
    if (!reset) begin
      if (max_tick) tick_seen++;
      if (rr.rnd_valid || (|rr.gnt)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_grant: gnt=%b data=0x%0h, no grant expected", rr.gnt, rr.rnd_data);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("gnt_onehot", 32'($countones(rr.gnt)), 32'd1);
          check("gnt", 32'(rr.gnt), 32'(e[EW-1:13]));
          check("rnd_valid", 32'(rr.rnd_valid), 32'd1);
          check("rnd_data", 32'(rr.rnd_data), 32'(e[12:0]));
        end
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rr.req = '0;
    step_tick = 1'b0;
    seed_load = 1'b0;
    pending = '0;
    #1;
    check("rst_lfsr", 32'(lfsr_out), 32'(SEED));
    check("rst_gnt", 32'(rr.gnt), 32'd0);
    check("rst_valid", 32'(rr.rnd_valid), 32'd0);
    check("rst_data", 32'(rr.rnd_data), 32'd0);
    check("rst_tick", 32'(max_tick), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    exp_q.delete();
    model_lfsr = SEED;
    model_steps = 0;
    model_last = NREQ - 1;
    model_data = 13'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One arbitration round (3 cycles) or a single idle cycle when nothing is
  // pending. Called just after a negedge with the DUT in IDLE.
  // st_mode: 0 no step_tick, 1 step_tick, 2 random.
  task automatic round(input logic [NREQ-1:0] arrive, input int st_mode);
    logic [NREQ-1:0] w1h;
    logic st;
    int w;
    pending = pending | arrive;
    st = (st_mode == 2) ? 1'($urandom_range(0, 1)) : (st_mode == 1);
    rr.req = pending;
    step_tick = st;
    if (pending != '0) begin
      w = model_pick(pending);
      model_adv();
      w1h = '0;
      w1h[w] = 1'b1;
      exp_q.push_back({w1h, model_lfsr});
      model_last = w;
      model_data = model_lfsr;
      @(negedge clk);
      step_tick = 1'($urandom_range(0, 1));
      check("busy_step", 32'(busy), 32'd1);
      @(negedge clk);
      check("busy_grant", 32'(busy), 32'd1);
      pending = pending & ~w1h;
      rr.req = pending;
      step_tick = 1'($urandom_range(0, 1));
      @(negedge clk);
      step_tick = 1'b0;
      check("busy_idle", 32'(busy), 32'd0);
      check("rnd_data_hold", 32'(rr.rnd_data), 32'(model_data));
    end else begin
      if (st) model_adv();
      @(negedge clk);
      step_tick = 1'b0;
      check("busy_idle", 32'(busy), 32'd0);
      check("idle_gnt", 32'(rr.gnt), 32'd0);
    end
    check("lfsr_out", 32'(lfsr_out), 32'(model_lfsr));
  endtask

  // Full period of free-running steps; DUT in IDLE, nothing pending.
  task automatic period_check();
    logic [12:0] start;
    int early;
    start = lfsr_out;
    early = 0;
    for (int i = 1; i <= 8191; i++) begin
      step_tick = 1'b1;
      @(negedge clk);
      model_adv();
      if (i < 8191 && max_tick) early++;
    end
    step_tick = 1'b0;
    check("period_early_tick", 32'(early), 32'd0);
    check("period_tick", 32'(max_tick), 32'd1);
    check("period_lfsr_start", 32'(lfsr_out), 32'(start));
    check("period_lfsr_model", 32'(lfsr_out), 32'(model_lfsr));
    @(negedge clk);
    check("period_tick_pulse", 32'(max_tick), 32'd0);
  endtask

  task automatic seed_cycle(input logic [12:0] v, input logic st);
    rr.req = '0;
    seed_load = 1'b1;
    seed_val = v;
    step_tick = st;
    @(negedge clk);
    seed_load = 1'b0;
    step_tick = 1'b0;
    rr.req = pending;
    model_lfsr = (v == 13'd0) ? SEED : v;
    model_steps = 0;
    check("seed_lfsr", 32'(lfsr_out), 32'(model_lfsr));
    check("seed_busy", 32'(busy), 32'd0);
  endtask

  logic [12:0] t1_vals [3];

  initial begin
    t1_vals[0] = 13'h0003;
    t1_vals[1] = 13'h0007;
    t1_vals[2] = 13'h000E;
    rr.req = '0;
    pending = '0;

    // Free-run steps from reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      round('0, 1);
      check("t1_lfsr", 32'(lfsr_out), 32'(t1_vals[i]));
      check("t1_tick", 32'(max_tick), 32'd0);
    end

    // Single request from reset
    do_reset();
    round(4'b0001, 0);
    check("t2_data", 32'(rr.rnd_data), 32'h0003);
    round('0, 0);
    check("t2_data_hold", 32'(rr.rnd_data), 32'h0003);

    // All requesters held, each dropping on its own grant
    do_reset();
    for (int i = 0; i < 5; i++) round('1, 0);

    // Full period from reset
    do_reset();
    period_check();

    // seed_load of zero while in STEP aborts the grant
    do_reset();
    round('0, 1);
    round('0, 1);
    rr.req = 4'b0001;
    @(negedge clk);
    rr.req = '0;
    seed_load = 1'b1;
    seed_val = 13'd0;
    check("t5_busy_step", 32'(busy), 32'd1);
    @(negedge clk);
    seed_load = 1'b0;
    model_lfsr = SEED;
    model_steps = 0;
    check("t5_lfsr", 32'(lfsr_out), 32'h0001);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_gnt", 32'(rr.gnt), 32'd0);
    check("t5_data", 32'(rr.rnd_data), 32'd0);
    @(negedge clk);
    check("t5_gnt_after", 32'(rr.gnt), 32'd0);
    period_check();
    seed_cycle(13'h1ABC, 1'b1);
    check("t5_seed_1abc", 32'(lfsr_out), 32'h1ABC);

    // step_tick coinciding with a request gives one advance
    do_reset();
    round(4'b0010, 1);
    check("t6_lfsr", 32'(lfsr_out), 32'h0003);
    check("t6_data", 32'(rr.rnd_data), 32'h0003);

    // Asynchronous reset in the middle of a grant
    do_reset();
    round('0, 1);
    rr.req = 4'b0100;
    @(negedge clk);
    check("t7_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t7_async_busy", 32'(busy), 32'd0);
    check("t7_async_lfsr", 32'(lfsr_out), 32'(SEED));
    rr.req = '0;
    do_reset();

    // Randomized rounds
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        seed_cycle((($urandom_range(0, 3)) == 0) ? 13'd0 : 13'($urandom_range(1, 8191)), 1'($urandom_range(0, 1)));
      end else if (r < 10) begin
        round(NREQ'($urandom_range(0, (1 << NREQ) - 1)), 2);
      end else begin
        round('0, 2);
      end
    end
    while (pending != '0) round('0, 0);
    @(negedge clk);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("max_tick_count", 32'(tick_seen), 32'(exp_ticks));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Overall time limit
  initial begin
    #2000000;
    n_cmp++;
    n_bad++;
    $display("FAIL timeout: run did not complete within the time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_rr_server.md
Name: lfsr_rr_server

Overview:
- Owns a 13-bit maximal-length Fibonacci LFSR and shares it between NREQ requesters using round-robin arbitration.
- Each granted request forces one fresh LFSR advance and delivers the new value with a one-cycle grant/valid pulse.
- While no request is pending, the LFSR free-runs on step_tick. step_tick comes from the team's clock-divider block.
- Provides seed loading, a period-wrap tick and a busy flag. The block sits between the clock divider and LFSR consumers in the top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SEED, 13'h0001, reset value of the LFSR; also substituted whenever a zero seed is loaded.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- step_tick  input  1  free-run advance strobe; honoured in IDLE only.
- req  input  NREQ  per-requester request; held high until own gnt is seen.
- gnt  output  NREQ  one-hot grant, one-cycle pulse.
- rnd_valid  output  1  high together with any gnt bit.
- rnd_data  output  13  value delivered with the last grant.
- seed_load  input  1  load seed_val into the LFSR (highest priority).
- seed_val  input  13  seed value.
- lfsr_out  output  13  live LFSR state.
- max_tick  output  1  one-cycle pulse on each completed 8191-step period.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Interface: one clock domain, clk. Reset is asynchronous and active-high on reset.
- Values on reset:
  - LFSR = SEED, FSM = IDLE.
  - gnt = 0, rnd_valid = 0, rnd_data = 0, max_tick = 0.
  - Step counter = 0.
  - RR pointer last = NREQ-1, so req[0] has top priority first.
- LFSR advance: fb = l[12]^l[3]^l[2]^l[0]; next = {l[11:0], fb}. This is polynomial x^13+x^4+x^3+x+1, period 8191.
- Step counter (0..8190) increments on every advance, including forced grant advances.
  - On an advance taking the counter from 8190 to 0, max_tick pulses for the next cycle.
  - The LFSR is back at its start value at that point.
- FSM states: IDLE, STEP, GRANT. All outputs are registered.
- IDLE:
  - If any req bit is set: winner = first requester with req high, scanning from last+1 with wrap; latch the winner, go to STEP. A step_tick in the same cycle is dropped, so there is exactly one advance.
  - Else, if step_tick: advance the LFSR and stay in IDLE.
- STEP: advance the LFSR. gnt[winner] <= 1, rnd_valid <= 1, rnd_data <= advanced value, last <= winner. Go to GRANT.
- GRANT: gnt <= 0, rnd_valid <= 0, go to IDLE. req is not sampled in this state.
- Latency: req seen at edge E0 -> gnt/rnd_valid high from E1 to E2 -> back in IDLE at E2 -> next arbitration at E3. One grant per 3 cycles maximum.
- Requester protocol: drop req during its gnt cycle. A req still high at E3 is treated as a new request.
- step_tick in STEP or GRANT is ignored, not queued.
- rnd_data holds its value between grants.
- busy = (state != IDLE).
- seed_load (any state, overrides everything in that cycle):
  - LFSR <= (seed_val == 0) ? SEED : seed_val.
  - Counter <= 0, FSM <= IDLE, gnt <= 0, rnd_valid <= 0; an in-flight grant is aborted.
  - last and rnd_data are unchanged; no max_tick.
- Reset asserted mid-operation returns everything to the reset values immediately, without waiting for a clock edge.
- The LFSR can never hold 0.

Optional Feature:
- Macro: LFSR_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. last is not used and not updated.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset, no req, three step_ticks in IDLE -> lfsr_out 0x0003, 0x0007, 0x000E; gnt = 0; busy = 0; max_tick = 0.
- From reset, req=0001 for one edge, then dropped on gnt -> gnt=0001 and rnd_valid high for exactly one cycle, 1 cycle after req sampled. rnd_data = 0x0003, held afterwards; busy high for 2 cycles.
- All four req held, each dropping on its own gnt and reasserting next cycle -> grant order 0,1,2,3,0. rnd_data 0x0003, 0x0007, 0x000E, …; never two gnt bits set at once.
- From reset, 8191 step_ticks with no req -> single max_tick pulse after the 8191st advance; lfsr_out = 0x0001 again; no earlier pulse.
- seed_load with seed_val=0 in the cycle the FSM is in STEP -> lfsr_out = 0x0001, no gnt that round, counter cleared, busy = 0 next cycle. Loading seed_val=0x1ABC -> lfsr_out = 0x1ABC.
- step_tick and req=0010 in the same IDLE cycle -> exactly one advance (0x0001 -> 0x0003); gnt=0010 with rnd_data = 0x0003.
